// File: rtl/timer_bank_pkg.sv
// timer_bank_pkg: shared constants and types for the timer bank.
//   - register offsets within a channel window and global register addresses
//   - CTRL / STATUS bit positions
//   - ID magic value
//   - ctrl_t packed CTRL layout
//   - lane_bits(): expands a 4-bit byte-enable into a 32-bit bit mask
package timer_bank_pkg;

    // Offsets inside a 16-byte channel window (bits [1:0] already cleared)
    localparam logic [3:0] OFF_COUNT  = 4'h0;
    localparam logic [3:0] OFF_RELOAD = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    // Global registers
    localparam logic [15:0] ADDR_PRESCALE = 16'h0100;
    localparam logic [15:0] ADDR_IRQ_PEND = 16'h0104;
    localparam logic [15:0] ADDR_ID       = 16'h0108;

    localparam int CTRL_ENABLE_BIT    = 0;
    localparam int CTRL_PERIODIC_BIT  = 1;
    localparam int CTRL_IRQ_EN_BIT    = 2;
    localparam int STATUS_EXPIRED_BIT = 0;

    // Upper half of the ID register; lower half is {NUM_CH, WIDTH}
    localparam logic [15:0] ID_MAGIC = 16'h7B01;

    // Member order puts enable at bit 0
    typedef struct packed {
        logic irq_en;
        logic periodic;
        logic enable;
    } ctrl_t;

    function automatic logic [31:0] lane_bits(input logic [3:0] wmask);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{wmask[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/timer_bank_channel.sv
// timer_channel: one down-counting timer channel.
//   clock, reset      : posedge clock, async active-high reset
//   tick              : prescaler pulse, one cycle wide
//   wr_count/reload/ctrl/status : decoded write strobes for this channel
//   wdata, wbits      : bus write data and byte-lane expanded bit mask
//   count, reload     : COUNT / RELOAD registers
//   ctrl              : CTRL register
//   expired           : STATUS.expired (sticky, write-1-to-clear)
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             wr_count,
    input  logic             wr_reload,
    input  logic             wr_ctrl,
    input  logic             wr_status,
    input  logic [31:0]      wdata,
    input  logic [31:0]      wbits,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] reload,
    output ctrl_t            ctrl,
    output logic             expired
);

    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] wm;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] reload_d;
    ctrl_t            ctrl_d;
    logic             expired_d;
    logic             expire;

    // Bits at or above WIDTH are dropped here
    assign wd = wdata[WIDTH-1:0];
    assign wm = wbits[WIDTH-1:0];

    logic unused_hi;
    assign unused_hi = ^{wdata, wbits};

    assign expire = tick && ctrl.enable && (count == '0);

    // Bus writes are applied after the timer update so that they win
    // over decrement, reload and one-shot enable clear. The expiry set
    // is applied last so it wins over a same-cycle W1C.
    always_comb begin
        count_d   = count;
        reload_d  = reload;
        ctrl_d    = ctrl;
        expired_d = expired;

        if (tick && ctrl.enable) begin
            if (count != '0) begin
                count_d = count - WIDTH'(1);
            end else if (ctrl.periodic) begin
                count_d = reload;
            end else begin
                ctrl_d.enable = 1'b0;
            end
        end

        if (wr_count) begin
            count_d = (count & ~wm) | (wd & wm);
        end
        if (wr_reload) begin
            reload_d = (reload & ~wm) | (wd & wm);
        end
        if (wr_ctrl && wbits[0]) begin
            ctrl_d.enable   = wdata[CTRL_ENABLE_BIT];
            ctrl_d.periodic = wdata[CTRL_PERIODIC_BIT];
            ctrl_d.irq_en   = wdata[CTRL_IRQ_EN_BIT];
        end
        if (wr_status && wbits[0] && wdata[STATUS_EXPIRED_BIT]) begin
            expired_d = 1'b0;
        end
        if (expire) begin
            expired_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count   <= '0;
            reload  <= '0;
            ctrl    <= '0;
            expired <= 1'b0;
        end else begin
            count   <= count_d;
            reload  <= reload_d;
            ctrl    <= ctrl_d;
            expired <= expired_d;
        end
    end

endmodule

// File: rtl/timer_bank.sv
// timer_bank: bank of NUM_CH down-counting timers behind a simple bus.
//   clock, reset  : posedge clock, async active-high reset
//   tmr_request   : one-cycle bus request; tmr_write selects write/read
//   tmr_address   : byte address, bits [1:0] ignored
//   tmr_wmask     : byte enables for writes
//   tmr_wdata     : write data; on reads [8:0] is the tag
//   tmr_rvalid    : read response strobe, one cycle after the request
//   tmr_rtag      : tag echoed with the response
//   tmr_rdata     : read data, 0 when tmr_rvalid is low
//   irq_vec, irq  : registered per-channel interrupts and their OR
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tmr_request,
    input  logic              tmr_write,
    input  logic [15:0]       tmr_address,
    input  logic [3:0]        tmr_wmask,
    input  logic [31:0]       tmr_wdata,
    output logic              tmr_rvalid,
    output logic [8:0]        tmr_rtag,
    output logic [31:0]       tmr_rdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);

    logic        wr;
    logic        rd;
    logic [15:0] addr_w;
    logic        in_chan_space;
    logic [3:0]  ch_sel;
    logic [3:0]  reg_off;
    logic [31:0] wbits;

    assign wr            = tmr_request &  tmr_write;
    assign rd            = tmr_request & ~tmr_write;
    assign addr_w        = {tmr_address[15:2], 2'b00};
    assign in_chan_space = (addr_w[15:8] == 8'h00);
    assign ch_sel        = addr_w[7:4];
    assign reg_off       = addr_w[3:0];
    assign wbits         = lane_bits(tmr_wmask);

    logic unused_addr;
    assign unused_addr = ^tmr_address[1:0];

    // ---------------- write decode ----------------
    logic [NUM_CH-1:0] wr_count;
    logic [NUM_CH-1:0] wr_reload;
    logic [NUM_CH-1:0] wr_ctrl;
    logic [NUM_CH-1:0] wr_status;

    always_comb begin
        wr_count  = '0;
        wr_reload = '0;
        wr_ctrl   = '0;
        wr_status = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr && in_chan_space && (ch_sel == 4'(i))) begin
                wr_count[i]  = (reg_off == OFF_COUNT);
                wr_reload[i] = (reg_off == OFF_RELOAD);
                wr_ctrl[i]   = (reg_off == OFF_CTRL);
                wr_status[i] = (reg_off == OFF_STATUS);
            end
        end
    end

    // ---------------- prescaler ----------------
    logic [PRESCALE_W-1:0] presc;
    logic [PRESCALE_W-1:0] presc_d;
    logic [PRESCALE_W-1:0] pcnt;
    logic                  tick;
    logic                  presc_wr;

    assign presc_wr = wr && (addr_w == ADDR_PRESCALE);
    assign presc_d  = (presc & ~wbits[PRESCALE_W-1:0])
                    | (tmr_wdata[PRESCALE_W-1:0] & wbits[PRESCALE_W-1:0]);
    // PRESCALE = 0 keeps pcnt at 0, so tick is high every cycle
    assign tick     = (pcnt == presc);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc <= '0;
            pcnt  <= '0;
        end else if (presc_wr) begin
            presc <= presc_d;
            pcnt  <= '0;
        end else if (tick) begin
            pcnt  <= '0;
        end else begin
            pcnt  <= pcnt + PRESCALE_W'(1);
        end
    end

    // ---------------- channels ----------------
    logic  [NUM_CH-1:0][WIDTH-1:0] count_all;
    logic  [NUM_CH-1:0][WIDTH-1:0] reload_all;
    ctrl_t [NUM_CH-1:0]            ctrl_all;
    logic  [NUM_CH-1:0]            expired_all;
    logic  [NUM_CH-1:0]            irq_en_all;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clock     (clock),
            .reset     (reset),
            .tick      (tick),
            .wr_count  (wr_count[g]),
            .wr_reload (wr_reload[g]),
            .wr_ctrl   (wr_ctrl[g]),
            .wr_status (wr_status[g]),
            .wdata     (tmr_wdata),
            .wbits     (wbits),
            .count     (count_all[g]),
            .reload    (reload_all[g]),
            .ctrl      (ctrl_all[g]),
            .expired   (expired_all[g])
        );
        assign irq_en_all[g] = ctrl_all[g].irq_en;
    end

    // ---------------- read mux ----------------
    logic [31:0] rd_val;
    logic [31:0] id_val;

    assign id_val = {ID_MAGIC, 8'(NUM_CH), 8'(WIDTH)};

    always_comb begin
        rd_val = '0;
        if (in_chan_space) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_sel == 4'(i)) begin
                    case (reg_off)
                        OFF_COUNT:  rd_val = 32'(count_all[i]);
                        OFF_RELOAD: rd_val = 32'(reload_all[i]);
                        OFF_CTRL:   rd_val = 32'(ctrl_all[i]);
                        OFF_STATUS: rd_val = 32'(expired_all[i]);
                        default:    rd_val = '0;
                    endcase
                end
            end
        end else if (addr_w == ADDR_PRESCALE) begin
            rd_val = 32'(presc);
        end else if (addr_w == ADDR_IRQ_PEND) begin
            rd_val = 32'(irq_vec);
        end else if (addr_w == ADDR_ID) begin
            rd_val = id_val;
        end
    end

    // Response registers are cleared whenever no read was issued, which
    // keeps tmr_rdata at 0 outside a response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmr_rvalid <= 1'b0;
            tmr_rtag   <= '0;
            tmr_rdata  <= '0;
        end else if (rd) begin
            tmr_rvalid <= 1'b1;
            tmr_rtag   <= tmr_wdata[8:0];
            tmr_rdata  <= rd_val;
        end else begin
            tmr_rvalid <= 1'b0;
            tmr_rtag   <= '0;
            tmr_rdata  <= '0;
        end
    end

    // ---------------- interrupts ----------------
    // Extra register stage: irq_vec follows expired/irq_en one cycle later
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_vec <= '0;
        end else begin
            irq_vec <= expired_all & irq_en_all;
        end
    end

    assign irq = |irq_vec;

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed, table-driven bench for timer_bank.
// Two instances share the bus: dut (defaults) and dut16 (WIDTH = 16).
module tb_timer_bank;

    logic        clock = 1'b0;
    logic        reset;
    logic        request;
    logic        write;
    logic [15:0] address;
    logic [3:0]  wmask;
    logic [31:0] wdata;

    logic        rvalid,   rvalid16;
    logic [8:0]  rtag,     rtag16;
    logic [31:0] rdata,    rdata16;
    logic        irq,      irq16;
    logic [3:0]  irq_vec,  irq_vec16;

    int checks = 0;
    int errors = 0;
    int tag_n  = 0;

    always #5 clock = ~clock;

    timer_bank dut (
        .clock(clock), .reset(reset),
        .tmr_request(request), .tmr_write(write), .tmr_address(address),
        .tmr_wmask(wmask), .tmr_wdata(wdata),
        .tmr_rvalid(rvalid), .tmr_rtag(rtag), .tmr_rdata(rdata),
        .irq(irq), .irq_vec(irq_vec)
    );

    timer_bank #(.NUM_CH(4), .WIDTH(16), .PRESCALE_W(16)) dut16 (
        .clock(clock), .reset(reset),
        .tmr_request(request), .tmr_write(write), .tmr_address(address),
        .tmr_wmask(wmask), .tmr_wdata(wdata),
        .tmr_rvalid(rvalid16), .tmr_rtag(rtag16), .tmr_rdata(rdata16),
        .irq(irq16), .irq_vec(irq_vec16)
    );

    typedef struct {
        logic [15:0] waddr;
        logic [31:0] wdat;
        logic [3:0]  wm;
        logic [15:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    logic [31:0] cnt_seq[8];
    logic [31:0] irq_seq[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
        request = 1'b1; write = 1'b1; address = a; wdata = d; wmask = m;
        @(negedge clock);
        request = 1'b0; write = 1'b0; wmask = 4'h0; wdata = '0;
    endtask

    task automatic bus_read(input string name, input logic [15:0] a,
                            output logic [31:0] d, output logic [31:0] d16);
        logic [8:0] tag;
        tag = 9'(tag_n * 37 + 11);
        tag_n++;
        request = 1'b1; write = 1'b0; address = a; wdata = {23'b0, tag}; wmask = 4'h0;
        @(negedge clock);
        request = 1'b0; wdata = '0;
        check({name, "_rvalid"}, 32'(rvalid), 32'd1);
        check({name, "_rtag"},   32'(rtag),   32'(tag));
        d   = rdata;
        d16 = rdata16;
    endtask

    task automatic expect_read(input string name, input logic [15:0] a, input logic [31:0] exp);
        logic [31:0] d, d16;
        bus_read(name, a, d, d16);
        check(name, d, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, d16;

        vecs[0]  = '{16'h0004, 32'h12345678, 4'hF, 16'h0004, 32'h12345678};
        vecs[1]  = '{16'h0010, 32'hDEADBEEF, 4'h5, 16'h0010, 32'h00AD00EF};
        vecs[2]  = '{16'h0028, 32'hFFFFFFFE, 4'hF, 16'h0028, 32'h00000006};
        vecs[3]  = '{16'h0034, 32'hCAFEF00D, 4'hC, 16'h0034, 32'hCAFE0000};
        vecs[4]  = '{16'h0100, 32'h12345678, 4'hF, 16'h0100, 32'h00005678};
        vecs[5]  = '{16'h0040, 32'h11111111, 4'hF, 16'h0040, 32'h00000000};
        vecs[6]  = '{16'h0108, 32'hFFFFFFFF, 4'hF, 16'h0108, 32'h7B010420};
        vecs[7]  = '{16'h0104, 32'hFFFFFFFF, 4'hF, 16'h0104, 32'h00000000};
        vecs[8]  = '{16'h0200, 32'hFFFFFFFF, 4'hF, 16'h0200, 32'h00000000};
        vecs[9]  = '{16'h000C, 32'hFFFFFFFF, 4'hF, 16'h000C, 32'h00000000};
        vecs[10] = '{16'h0013, 32'h00000055, 4'h1, 16'h0010, 32'h00AD0055};
        vecs[11] = '{16'h002A, 32'h00000000, 4'h1, 16'h0028, 32'h00000000};

        cnt_seq = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0};
        irq_seq = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1};

        request = 1'b0; write = 1'b0; address = '0; wdata = '0; wmask = '0;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);

        // ---- reset state ----
        check("rst_rvalid",  32'(rvalid),   32'd0);
        check("rst_rtag",    32'(rtag),     32'd0);
        check("rst_rdata",   rdata,         32'd0);
        check("rst_irq",     32'(irq),      32'd0);
        check("rst_irq_vec", 32'(irq_vec),  32'd0);
        check("rst16_rvalid",32'(rvalid16), 32'd0);
        check("rst16_irq",   32'(irq16),    32'd0);
        reset = 1'b0;
        @(negedge clock);

        // ---- table: write then read back ----
        for (int i = 0; i < 12; i++) begin
            bus_write(vecs[i].waddr, vecs[i].wdat, vecs[i].wm);
            expect_read($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
        end

        // ---- ID read with tag, response only for one cycle ----
        request = 1'b1; write = 1'b0; address = 16'h0108; wdata = 32'h000001A5;
        @(negedge clock);
        request = 1'b0; wdata = '0;
        check("id_rvalid",  32'(rvalid), 32'd1);
        check("id_rtag",    32'(rtag),   32'h1A5);
        check("id_rdata",   rdata,       32'h7B010420);
        check("id16_rdata", rdata16,     32'h7B010410);
        @(negedge clock);
        check("idle_rvalid", 32'(rvalid), 32'd0);
        check("idle_rdata",  rdata,       32'd0);

        // ---- periodic, PRESCALE = 0 ----
        do_reset();
        bus_write(16'h0100, 32'd0, 4'hF);
        bus_write(16'h0004, 32'd3, 4'hF);
        bus_write(16'h0000, 32'd3, 4'hF);
        bus_write(16'h0008, 32'd7, 4'hF);
        for (int k = 0; k < 8; k++) begin
            request = 1'b1; write = 1'b0; address = 16'h0000; wdata = 32'(k);
            @(negedge clock);
            check($sformatf("per_rvalid%0d", k), 32'(rvalid), 32'd1);
            check($sformatf("per_count%0d", k),  rdata,       cnt_seq[k]);
            check($sformatf("per_irq%0d", k),    32'(irq),    irq_seq[k]);
        end
        request = 1'b0; wdata = '0;

        // ---- W1C same cycle as expiry: set wins; later W1C clears ----
        do_reset();
        bus_write(16'h0100, 32'd0, 4'hF);
        bus_write(16'h0004, 32'd3, 4'hF);
        bus_write(16'h0000, 32'd3, 4'hF);
        bus_write(16'h0008, 32'd7, 4'hF);
        repeat (7) @(negedge clock);
        bus_write(16'h000C, 32'd1, 4'h1);
        expect_read("w1c_setwins", 16'h000C, 32'd1);
        check("w1c_irq_before", 32'(irq), 32'd1);
        bus_write(16'h0008, 32'd4, 4'hF);
        bus_write(16'h000C, 32'd1, 4'h1);
        check("w1c_irq_lag", 32'(irq), 32'd1);
        @(negedge clock);
        check("w1c_irq_drop", 32'(irq), 32'd0);
        expect_read("w1c_cleared", 16'h000C, 32'd0);

        // ---- one-shot, PRESCALE = 9 ----
        do_reset();
        bus_write(16'h0100, 32'd9, 4'hF);
        bus_write(16'h0000, 32'd2, 4'hF);
        bus_write(16'h0008, 32'd1, 4'hF);
        repeat (27) @(negedge clock);
        expect_read("os_before", 16'h000C, 32'd0);
        expect_read("os_expired", 16'h000C, 32'd1);
        expect_read("os_ctrl", 16'h0008, 32'd0);
        expect_read("os_count", 16'h0000, 32'd0);
        repeat (15) @(negedge clock);
        expect_read("os_count_hold", 16'h0000, 32'd0);
        expect_read("os_status_hold", 16'h000C, 32'd1);
        check("os_irq", 32'(irq), 32'd0);

        // ---- CTRL write wins over one-shot enable clear ----
        do_reset();
        bus_write(16'h0008, 32'd1, 4'hF);
        bus_write(16'h0008, 32'd1, 4'hF);
        expect_read("ctrlprio_kept", 16'h0008, 32'd1);
        expect_read("ctrlprio_clr", 16'h0008, 32'd0);
        expect_read("ctrlprio_stat", 16'h000C, 32'd1);

        // ---- byte-lane write with WIDTH = 16 ----
        do_reset();
        bus_write(16'h0000, 32'hAABBCCDD, 4'h2);
        bus_read("w16_cnt", 16'h0000, d, d16);
        check("w16_count16", d16, 32'h0000CC00);
        check("w16_count32", d,   32'h0000CC00);
        bus_write(16'h0004, 32'hAABBCCDD, 4'hF);
        bus_read("w16_rld", 16'h0004, d, d16);
        check("w16_reload16", d16, 32'h0000CCDD);
        check("w16_reload32", d,   32'hAABBCCDD);

        // ---- COUNT write priority, then reset mid-count with read pending ----
        do_reset();
        bus_write(16'h0004, 32'd7, 4'hF);
        bus_write(16'h0000, 32'd5, 4'hF);
        bus_write(16'h0008, 32'd7, 4'hF);
        bus_write(16'h0000, 32'h64, 4'hF);
        expect_read("cnt_wr_prio", 16'h0000, 32'h64);
        bus_write(16'h0000, 32'd1, 4'hF);
        repeat (4) @(negedge clock);
        check("pre_rst_irq", 32'(irq), 32'd1);
        request = 1'b1; write = 1'b0; address = 16'h0000; wdata = 32'h0AA;
        #2 reset = 1'b1;
        @(negedge clock);
        request = 1'b0; wdata = '0;
        check("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check("mid_rst_rdata",  rdata,       32'd0);
        check("mid_rst_irq",    32'(irq),    32'd0);
        @(negedge clock);
        reset = 1'b0;
        check("post_rst_rvalid", 32'(rvalid), 32'd0);
        expect_read("post_count",  16'h0000, 32'd0);
        expect_read("post_reload", 16'h0004, 32'd0);
        expect_read("post_ctrl",   16'h0008, 32'd0);
        expect_read("post_status", 16'h000C, 32'd0);
        expect_read("post_presc",  16'h0100, 32'd0);
        repeat (10) @(negedge clock);
        expect_read("post_status_late", 16'h000C, 32'd0);
        expect_read("post_irqpend", 16'h0104, 32'd0);
        check("post_irq", 32'(irq), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter NUM_CH, default 4, number of timer channels (legal range 1..8).
REQ-002 Parameter WIDTH, default 32, counter and reload width in bits (legal range 8..32).
REQ-003 Parameter PRESCALE_W, default 16, prescaler width in bits (legal range 1..32).
REQ-004 clock  input  1  single clock; all logic is posedge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 tmr_request  input  1  bus read or write request, valid for one cycle.
REQ-007 tmr_write  input  1  1 = write, 0 = read.
REQ-008 tmr_address  input  16  byte address within block; bits [1:0] ignored.
REQ-009 tmr_wmask  input  4  byte enables for writes.
REQ-010 tmr_wdata  input  32  write data; on reads, bits [8:0] carry the request tag.
REQ-011 tmr_rvalid  output  1  read response strobe.
REQ-012 tmr_rtag  output  9  tag returned with the read response.
REQ-013 tmr_rdata  output  32  read data.
REQ-014 irq  output  1  OR of irq_vec.
REQ-015 irq_vec  output  NUM_CH  per-channel interrupt: expired AND irq_en.

Function
REQ-016 Register map: channel n at 0x10*n; +0x0 COUNT RW, +0x4 RELOAD RW, +0x8 CTRL RW, +0xC STATUS R/W1C.
REQ-017 Global registers: 0x100 PRESCALE RW; 0x104 IRQ_PEND R (irq_vec, zero-extended); 0x108 ID R = {16'h7B01, NUM_CH[7:0], WIDTH[7:0]}.
REQ-018 CTRL bit fields: bit0 enable, bit1 periodic (0 = one-shot), bit2 irq_en; remaining bits read 0.
REQ-019 STATUS bit fields: bit0 expired; remaining bits read 0.
REQ-020 Writes apply per byte lane according to tmr_wmask; bits at or above WIDTH (or PRESCALE_W) are dropped and read as 0.
REQ-021 Reads have 1-cycle latency: tmr_rvalid = 1 exactly one cycle after a read request, with tmr_rtag = the wdata[8:0] captured on that request.
REQ-022 tmr_rdata shall be 0 whenever tmr_rvalid = 0, and also on reads of unmapped addresses or channels >= NUM_CH.
REQ-023 Writes to unmapped addresses or read-only registers shall have no effect; writes produce no response.
REQ-024 Prescaler counter increments every cycle; when it equals PRESCALE it pulses tick for one cycle and wraps to 0.
REQ-025 PRESCALE = 0 shall give a tick every cycle.
REQ-026 A write to PRESCALE shall clear the prescaler counter.
REQ-027 On tick, with enable = 1 and COUNT != 0: COUNT decrements by 1.
REQ-028 On tick, with enable = 1 and COUNT = 0: expired is set to 1.
REQ-029 In the REQ-028 case, periodic = 1 also loads COUNT <= RELOAD; periodic = 0 clears enable and holds COUNT at 0.
REQ-030 With enable = 0, COUNT holds its value.
REQ-031 A COUNT write in the same cycle as a tick shall take priority over the decrement and over the reload.
REQ-032 A CTRL write in the same cycle as a one-shot expiry shall take priority over the enable clear.
REQ-033 A STATUS W1C in the same cycle as an expiry shall leave expired = 1 (set wins).
REQ-034 irq and irq_vec are driven from registered state only, with no combinational path from bus inputs.
REQ-035 irq_vec updates in the cycle after expired or irq_en changes.

Reset
REQ-036 While reset is high: COUNT, RELOAD, CTRL, STATUS, PRESCALE, the prescaler counter, tmr_rvalid, tmr_rtag, tmr_rdata, irq and irq_vec are all 0.
REQ-037 Reset asserted mid-read shall suppress the pending tmr_rvalid.
REQ-038 Reset asserted mid-count shall discard the count; no expiry is reported after release.

Structure
REQ-039 Package timer_bank_pkg holds: register offset constants, CTRL/STATUS bit index constants, the ID constant, and a ctrl_t packed struct.
REQ-040 Sub-module timer_channel (one per channel, via generate) holds COUNT, RELOAD, CTRL and STATUS, and receives tick plus decoded write strobes.
REQ-041 Top level holds: address decode, prescaler, read mux, and interrupt OR.

Verification
REQ-042 PRESCALE = 0, RELOAD = 3, COUNT = 3, CTRL = 0x7 -> expired/irq rise every 4 cycles; COUNT cycles 3,2,1,0.
REQ-043 PRESCALE = 9, COUNT = 2, CTRL = 0x1 (one-shot) -> expired set after 30 cycles; enable reads 0; COUNT stays 0.
REQ-044 Read of 0x108 with tag 0x1A5 (NUM_CH = 4, WIDTH = 32) -> next cycle rvalid = 1, rtag = 0x1A5, rdata = 0x7B010420.
REQ-045 STATUS W1C issued in the same cycle as an expiry -> expired stays 1; a W1C on a later cycle clears it and irq drops 1 cycle later.
REQ-046 Write 0xAABBCCDD to COUNT with wmask = 0x2, WIDTH = 16, prior value 0 -> COUNT reads 0x0000CC00.
REQ-047 Reset pulse while counting with a read outstanding -> no rvalid; all registers and irq read 0.
